ram_port_arbiter: RTL
=====================

# ram_port_arbiter

Shares one port of a dual-port block RAM (e.g. the write/fill port of a cache data array) between NREQ requesters. The block has three jobs:
- Arbitrates requests round-robin, one access per cycle.
- Routes read data back to the originating requester after the fixed RAM read latency.
- Optionally sequences a zero-fill of the whole array after reset.

It sits between requester logic and the `dual_port_ram` / `dual_port_lutram` wrappers, and drives their `en`/`we`/`addr`/`din` pins directly.

## Interface
Parameters:
- `NREQ`, 4, number of requesters (≥2).
- `DATA_WIDTH`, 32, word width.
- `SIZE`, 1024, RAM depth in words; `AW = $clog2(SIZE)`.
- `LATENCY`, 1, RAM read latency in cycles (≥1); must equal the attached RAM's setting.
- `CLEAR_ON_RESET`, 1, 1 = zero-fill all words after reset.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NREQ  per-requester request.
- `req_we`  in  NREQ  1 = write, 0 = read.
- `req_addr`  in  NREQ×AW  per-requester address.
- `req_wdata`  in  NREQ×DATA_WIDTH  per-requester write data.
- `req_ready`  out  NREQ  one-hot grant; the access is issued this cycle.
- `rsp_valid`  out  NREQ  one-hot read-data strobe.
- `rsp_rdata`  out  DATA_WIDTH  read data, shared bus, valid where `rsp_valid` is set.
- `busy`  out  1  clear sequence in progress.
- `ram_en`  out  1  RAM port enable.
- `ram_we`  out  1  RAM port write enable.
- `ram_addr`  out  AW  RAM port address.
- `ram_din`  out  DATA_WIDTH  RAM port write data.
- `ram_dout`  in  DATA_WIDTH  RAM port read data.

## Operation
- FSM states: CLEAR, RUN. Reset enters CLEAR if `CLEAR_ON_RESET`=1, otherwise RUN.
- CLEAR:
  - Drives `ram_en`=1, `ram_we`=1, `ram_din`=0, `ram_addr`=clear_cnt.
  - clear_cnt starts at 0 and increments each cycle.
  - After issuing address SIZE−1, the FSM moves to RUN.
  - All `req_ready`=0 and `busy`=1 throughout CLEAR.
- RUN, arbitration:
  - Grant goes to the lowest index ≥ rr_ptr with `req_valid`=1, searching modulo NREQ.
  - The grant is combinational. The granted requester's we/addr/wdata drive the ram_* pins, and `ram_en`=1.
  - On a grant to requester g, rr_ptr ← (g+1) mod NREQ.
  - With no valid request: `ram_en`=0 and rr_ptr holds.
- Handshake: a requester holds valid/we/addr/wdata stable until it sees `req_ready`=1. The transfer completes on that clock edge.
- Read return:
  - A LATENCY-deep shift pipeline carries {valid, id} for each granted read.
  - At the pipeline output: `rsp_valid[id]`=1 and `rsp_rdata`=`ram_dout`.
  - Writes generate no response.
  - Responses cannot be back-pressured.
- Same-address ordering: accesses are serialized, so a read granted after a write to the same address returns the new data.
- `rsp_rdata` is 0 whenever no `rsp_valid` bit is set.

## Timing
- While `rst`=1, every output is 0: `req_ready`, `rsp_valid`, `rsp_rdata`, `busy`, and all ram_* outputs. The pipeline, rr_ptr (0) and clear_cnt (0) clear asynchronously.
- Reset asserted mid-operation:
  - In-flight reads are discarded and no `rsp_valid` is produced for them.
  - The clear sequence restarts from address 0 after deassertion.
- Cycle 0 is the first cycle after `rst` deasserts.
- With `CLEAR_ON_RESET`=1:
  - Cycles 0..SIZE−1 are clear writes.
  - `busy` falls and the first grant is possible in cycle SIZE.
- With `CLEAR_ON_RESET`=0, `busy` stays 0 and a grant is possible in cycle 0.
- A read granted in cycle t produces `rsp_valid` in cycle t+LATENCY.
- Throughput is one access per cycle, including back-to-back reads from the same requester.
- A request already present in cycle 0 sees no starvation. Any continuously asserted request is granted within NREQ cycles of RUN.

## Test plan
- Clear check, SIZE=16, CLEAR_ON_RESET=1: release reset → `busy`=1 for exactly 16 cycles with writes of 0 to addr 0..15 in order; then read all 16 words → every `rsp_rdata`=0.
- Round-robin, all 4 requesters hold valid from RUN cycle 0 → grants follow 0,1,2,3,0,1… with exactly one `req_ready` bit per cycle.
- Read routing, LATENCY=2: req1 writes 0xDEADBEEF to addr 5, then req3 reads addr 5 → `rsp_valid`=4'b1000 with `rsp_rdata`=0xDEADBEEF exactly 2 cycles after the read grant; no response pulse for the write.
- Pointer hold: only req2 valid for 3 cycles → 3 consecutive grants to req2; then req0 and req3 both valid → req3 granted first (rr_ptr=3), then req0.
- Reset mid-flight: a read is granted, then `rst` pulses before the response → no `rsp_valid` ever appears for it; clear restarts at addr 0; all outputs are 0 during reset.
- Idle, no `req_valid` in RUN → `ram_en`=0 and `req_ready`=0; rr_ptr is unchanged on the next grant.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// Shares one port of a block RAM between NREQ requesters. A round-robin
// arbiter issues at most one access per cycle. Read data comes back after
// the RAM's fixed LATENCY and is steered to the requester that issued the
// read. After reset the block can optionally zero-fill every word before
// any requester is served.
//
// Ports
//   clk, rst    clock, asynchronous active-high reset
//   req_valid   per-requester request
//   req_we      per-requester write (1) / read (0)
//   req_addr    per-requester address, requester i at [i*AW +: AW]
//   req_wdata   per-requester write data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready   one-hot grant; the access is issued in this cycle
//   rsp_valid   one-hot read-data strobe
//   rsp_rdata   shared read data, zero when no rsp_valid bit is set
//   busy        zero-fill sequence in progress
//   ram_en/ram_we/ram_addr/ram_din  RAM port controls
//   ram_dout    RAM port read data
module ram_port_arbiter #(
  parameter int NREQ           = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int SIZE           = 1024,
  parameter int LATENCY        = 1,
  parameter int CLEAR_ON_RESET = 1,
  localparam int AW            = $clog2(SIZE)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ-1:0]            req_we,
  input  logic [NREQ*AW-1:0]         req_addr,
  input  logic [NREQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NREQ-1:0]            req_ready,
  output logic [NREQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]      rsp_rdata,
  output logic                       busy,
  output logic                       ram_en,
  output logic                       ram_we,
  output logic [AW-1:0]              ram_addr,
  output logic [DATA_WIDTH-1:0]      ram_din,
  input  logic [DATA_WIDTH-1:0]      ram_dout
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [AW-1:0] CLEAR_LAST = AW'(SIZE - 1);
  localparam logic [IW-1:0] PTR_LAST   = IW'(NREQ - 1);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t          state_r;
  state_t          state_next_s;
  logic [AW-1:0]   clear_cnt_r;
  logic [IW-1:0]   rr_ptr_r;
  logic            gnt_found_s;
  logic [IW-1:0]   gnt_id_s;
  logic            grant_s;
  logic            pipe_vld_r [LATENCY];
  logic [IW-1:0]   pipe_id_r  [LATENCY];

  // State register; reset lands in CLEAR only when zero-fill is enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic: leave CLEAR once the last address has been written.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_CLEAR: begin
        if (clear_cnt_r == CLEAR_LAST) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_CLEAR;
        end
      end
      ST_RUN:  state_next_s = ST_RUN;
      default: state_next_s = ST_RUN;
    endcase
  end

  // Zero-fill address counter; restarts from 0 on every reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clear_cnt_r <= {AW{1'b0}};
    end else if (state_r == ST_CLEAR) begin
      clear_cnt_r <= (clear_cnt_r == CLEAR_LAST) ? {AW{1'b0}} : clear_cnt_r + AW'(1);
    end else begin
      clear_cnt_r <= clear_cnt_r;
    end
  end

  // Round-robin search: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    gnt_found_s = 1'b0;
    gnt_id_s    = {IW{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      int raw_idx;
      int idx;
      raw_idx = int'(rr_ptr_r) + i;
      if (raw_idx >= NREQ) begin
        idx = raw_idx - NREQ;
      end else begin
        idx = raw_idx;
      end
      if (!gnt_found_s && req_valid[idx]) begin
        gnt_found_s = 1'b1;
        gnt_id_s    = IW'(idx);
      end else begin
        gnt_found_s = gnt_found_s;
      end
    end
  end

  assign grant_s = (state_r == ST_RUN) && gnt_found_s && !rst;

  // Pointer moves just past the winner; it holds while the port is idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_r <= {IW{1'b0}};
    end else if (grant_s) begin
      rr_ptr_r <= (gnt_id_s == PTR_LAST) ? {IW{1'b0}} : gnt_id_s + IW'(1);
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

  // Port drive: zero-fill writes in CLEAR, the granted access in RUN.
  // Everything is forced low while rst is high, including the grant.
  always_comb begin
    req_ready = {NREQ{1'b0}};
    busy      = 1'b0;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = {AW{1'b0}};
    ram_din   = {DATA_WIDTH{1'b0}};
    if (rst) begin
      busy = 1'b0;
    end else begin
      case (state_r)
        ST_CLEAR: begin
          busy     = 1'b1;
          ram_en   = 1'b1;
          ram_we   = 1'b1;
          ram_addr = clear_cnt_r;
        end
        ST_RUN: begin
          if (grant_s) begin
            req_ready[gnt_id_s] = 1'b1;
            ram_en   = 1'b1;
            ram_we   = req_we[gnt_id_s];
            ram_addr = req_addr[int'(gnt_id_s)*AW +: AW];
            ram_din  = req_wdata[int'(gnt_id_s)*DATA_WIDTH +: DATA_WIDTH];
          end else begin
            ram_en = 1'b0;
          end
        end
        default: begin
          busy = 1'b0;
        end
      endcase
    end
  end

  // Read-tag pipeline, as deep as the RAM latency; reset drops in-flight reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < LATENCY; k++) begin
        pipe_vld_r[k] <= 1'b0;
        pipe_id_r[k]  <= {IW{1'b0}};
      end
    end else begin
      pipe_vld_r[0] <= grant_s && !req_we[gnt_id_s];
      pipe_id_r[0]  <= gnt_id_s;
      for (int k = 1; k < LATENCY; k++) begin
        pipe_vld_r[k] <= pipe_vld_r[k-1];
        pipe_id_r[k]  <= pipe_id_r[k-1];
      end
    end
  end

  // Response steering; the shared data bus is zero when nothing returns.
  always_comb begin
    rsp_valid = {NREQ{1'b0}};
    rsp_rdata = {DATA_WIDTH{1'b0}};
    if (pipe_vld_r[LATENCY-1] && !rst) begin
      rsp_valid[pipe_id_r[LATENCY-1]] = 1'b1;
      rsp_rdata = ram_dout;
    end else begin
      rsp_rdata = {DATA_WIDTH{1'b0}};
    end
  end

endmodule
